// File: rtl/vga_pkg.sv
// Shared VGA geometry, boss sprite constants and the boss sprite image.
package vga_pkg;

    localparam int HOR_PIXELS = 1024;
    localparam int VER_PIXELS = 768;

    // Boss sprite half-extents in pixels (box is 2*BOSS_LNG x 2*BOSS_HGT).
    localparam int BOSS_LNG = 16;
    localparam int BOSS_HGT = 16;

    localparam logic [11:0] BOSS_KEY_COLOR    = 12'hF0F;
    localparam logic [11:0] BOSS_FLASH_COLOR  = 12'hFFF;
    localparam logic [7:0]  BOSS_FLASH_FRAMES = 8'd8;

    localparam int BOSS_W    = 2 * BOSS_LNG;
    localparam int BOSS_H    = 2 * BOSS_HGT;
    localparam int COL_BITS  = $clog2(BOSS_W);
    localparam int ROW_BITS  = $clog2(BOSS_H);
    localparam int ROM_DEPTH = BOSS_W * BOSS_H;
    localparam int ROM_AW    = COL_BITS + ROW_BITS;

    // Signed 13-bit copies of the box extents for screen-space comparisons.
    localparam logic signed [12:0] BOSS_LNG_S = 13'(BOSS_LNG);
    localparam logic signed [12:0] BOSS_HGT_S = 13'(BOSS_HGT);
    localparam logic signed [12:0] BOSS_W_S   = 13'(BOSS_W);
    localparam logic signed [12:0] BOSS_H_S   = 13'(BOSS_H);

    localparam logic [11:0] BOSS_X_RST = 12'(HOR_PIXELS - HOR_PIXELS / 4);
    localparam logic [11:0] BOSS_Y_RST = 12'(VER_PIXELS - 52 - BOSS_HGT);

    typedef enum logic {
        FACE_RIGHT = 1'b0,
        FACE_LEFT  = 1'b1
    } facing_t;

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
        logic [11:0] rgb;
    } vga_bus_t;

    // Boss image contents, indexed by row*BOSS_W + col. The two centre
    // pixels of the middle row hold 12'h123, every column with col%8==5 is
    // transparent, and all other pixels encode their own row/column.
    function automatic logic [11:0] boss_pixel(input logic [ROM_AW-1:0] addr);
        logic [ROW_BITS-1:0] row;
        logic [COL_BITS-1:0] col;
        logic [11:0]         pix;
        row = addr[ROM_AW-1:COL_BITS];
        col = addr[COL_BITS-1:0];
        if ((row == ROW_BITS'(BOSS_HGT)) &&
            ((col == COL_BITS'(BOSS_LNG)) || (col == COL_BITS'(BOSS_LNG - 1)))) begin
            pix = 12'h123;
        end else if (col[2:0] == 3'd5) begin
            pix = BOSS_KEY_COLOR;
        end else begin
            pix = 12'({row, col});
        end
        return pix;
    endfunction

endpackage

// File: rtl/boss_rom.sv
// Boss sprite storage: synchronous read with one cycle of latency.
module boss_rom
    import vga_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ROM_AW-1:0] addr,
    output logic [11:0]       data
);

    // Registered read port; cleared by reset so the pipeline restarts clean.
    always_ff @(posedge clk) begin
        if (rst) begin
            data <= 12'h000;
        end else begin
            data <= boss_pixel(addr);
        end
    end

endmodule

// File: rtl/boss_draw.sv
// Boss sprite overlay: two-stage pipeline merging the boss image into the
// incoming VGA stream, with per-frame position latch, facing and hit flash.
module boss_draw
    import vga_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic [1:0]  game_active,
    input  logic [11:0] boss_x,
    input  logic [11:0] boss_y,
    input  logic        boss_hit,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out
);

    // Frame-stable boss state
    logic [11:0] bx;
    logic [11:0] by;
    facing_t     facing;
    logic [7:0]  flash_cnt;

    // Stage 1 geometry
    logic signed [12:0]  hpos;
    logic signed [12:0]  vpos;
    logic signed [12:0]  box_x0;
    logic signed [12:0]  box_y0;
    logic signed [12:0]  col;
    logic signed [12:0]  row;
    logic [COL_BITS-1:0] col_src;
    logic [ROM_AW-1:0]   rom_addr;
    logic                in_box;
    logic                draw;
    logic                flash_on;

    // Pipeline registers
    vga_bus_t    s1_bus;
    logic        s1_draw;
    logic        s1_flash;
    logic [11:0] rom_data;
    vga_bus_t    out_bus;
    logic [11:0] rgb_merged;

    // Latch position, facing and flash counter once per frame / on hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            bx        <= BOSS_X_RST;
            by        <= BOSS_Y_RST;
            facing    <= FACE_RIGHT;
            flash_cnt <= 8'd0;
        end else begin
            if (frame_tick) begin
                bx <= boss_x;
                by <= boss_y;
                if (boss_x < bx) begin
                    facing <= FACE_LEFT;
                end else if (boss_x > bx) begin
                    facing <= FACE_RIGHT;
                end else begin
                    facing <= facing;
                end
            end
            if (game_active != 2'd1) begin
                flash_cnt <= 8'd0;
            end else if (boss_hit) begin
                flash_cnt <= BOSS_FLASH_FRAMES;
            end else if (frame_tick && (flash_cnt != 8'd0)) begin
                flash_cnt <= flash_cnt - 8'd1;
            end else begin
                flash_cnt <= flash_cnt;
            end
        end
    end

    // Box test in signed screen space (no wrap) and ROM address with mirroring.
    // Box dimensions are powers of two, so row*width+col is a concatenation.
    always_comb begin
        hpos   = $signed({2'b00, hcount_in});
        vpos   = $signed({2'b00, vcount_in});
        box_x0 = $signed({1'b0, bx}) - BOSS_LNG_S;
        box_y0 = $signed({1'b0, by}) - BOSS_HGT_S;
        in_box = (hpos >= box_x0) && (hpos < (box_x0 + BOSS_W_S)) &&
                 (vpos >= box_y0) && (vpos < (box_y0 + BOSS_H_S));
        col    = hpos - box_x0;
        row    = vpos - box_y0;
        if (facing == FACE_LEFT) begin
            col_src = COL_BITS'(BOSS_W - 1) - col[COL_BITS-1:0];
        end else begin
            col_src = col[COL_BITS-1:0];
        end
        rom_addr = {row[ROW_BITS-1:0], col_src};
        draw     = in_box && !hblnk_in && !vblnk_in && (game_active == 2'd1);
        flash_on = (flash_cnt != 8'd0) && flash_cnt[0];
    end

    boss_rom u_rom (
        .clk  (clk),
        .rst  (rst),
        .addr (rom_addr),
        .data (rom_data)
    );

    // Stage 1: carry timing, background and draw decision alongside the ROM read.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_bus   <= '0;
            s1_draw  <= 1'b0;
            s1_flash <= 1'b0;
        end else begin
            s1_bus.hcount <= hcount_in;
            s1_bus.vcount <= vcount_in;
            s1_bus.hsync  <= hsync_in;
            s1_bus.vsync  <= vsync_in;
            s1_bus.hblnk  <= hblnk_in;
            s1_bus.vblnk  <= vblnk_in;
            s1_bus.rgb    <= rgb_in;
            s1_draw       <= draw;
            s1_flash      <= flash_on;
        end
    end

    // Pick sprite, flash or background colour for the stage-2 register.
    always_comb begin
        if (s1_draw && (rom_data != BOSS_KEY_COLOR)) begin
            if (s1_flash) begin
                rgb_merged = BOSS_FLASH_COLOR;
            end else begin
                rgb_merged = rom_data;
            end
        end else begin
            rgb_merged = s1_bus.rgb;
        end
    end

    // Stage 2: registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_bus <= '0;
        end else begin
            out_bus     <= s1_bus;
            out_bus.rgb <= rgb_merged;
        end
    end

    assign hcount_out = out_bus.hcount;
    assign vcount_out = out_bus.vcount;
    assign hsync_out  = out_bus.hsync;
    assign vsync_out  = out_bus.vsync;
    assign hblnk_out  = out_bus.hblnk;
    assign vblnk_out  = out_bus.vblnk;
    assign rgb_out    = out_bus.rgb;

endmodule

// File: tb/tb_boss_draw.sv
// Self-checking bench for boss_draw: scoreboard of expected outputs pushed
// per driven cycle and popped two cycles later, plus directed scenario checks.
module tb_boss_draw;

    logic        clk;
    logic        rst;
    logic        frame_tick;
    logic [1:0]  game_active;
    logic [11:0] boss_x;
    logic [11:0] boss_y;
    logic        boss_hit;
    logic [10:0] hcount_in;
    logic [10:0] vcount_in;
    logic        hsync_in;
    logic        vsync_in;
    logic        hblnk_in;
    logic        vblnk_in;
    logic [11:0] rgb_in;
    logic [10:0] hcount_out;
    logic [10:0] vcount_out;
    logic        hsync_out;
    logic        vsync_out;
    logic        hblnk_out;
    logic        vblnk_out;
    logic [11:0] rgb_out;

    int          n_cmp;
    int          n_bad;
    string       cur;
    logic [37:0] sbq[$];

    // Reference model state
    logic [11:0] mbx;
    logic [11:0] mby;
    bit          mleft;
    int          mflash;

    boss_draw dut (
        .clk         (clk),
        .rst         (rst),
        .frame_tick  (frame_tick),
        .game_active (game_active),
        .boss_x      (boss_x),
        .boss_y      (boss_y),
        .boss_hit    (boss_hit),
        .hcount_in   (hcount_in),
        .vcount_in   (vcount_in),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .hblnk_in    (hblnk_in),
        .vblnk_in    (vblnk_in),
        .rgb_in      (rgb_in),
        .hcount_out  (hcount_out),
        .vcount_out  (vcount_out),
        .hsync_out   (hsync_out),
        .vsync_out   (vsync_out),
        .hblnk_out   (hblnk_out),
        .vblnk_out   (vblnk_out),
        .rgb_out     (rgb_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sprite image as a 32x32 picture.
    function automatic logic [11:0] rom_pix(input int row, input int col);
        if (row == 16 && (col == 15 || col == 16)) return 12'h123;
        if (col % 8 == 5) return 12'hF0F;
        return 12'(row * 32 + col);
    endfunction

    function automatic logic [37:0] model_out();
        int h, v, x0, y0, col, row;
        logic [11:0] pix, c;
        h  = int'(hcount_in);
        v  = int'(vcount_in);
        x0 = int'(mbx) - 16;
        y0 = int'(mby) - 16;
        c  = rgb_in;
        if (h >= x0 && h < x0 + 32 && v >= y0 && v < y0 + 32 &&
            !hblnk_in && !vblnk_in && game_active == 2'd1) begin
            col = h - x0;
            row = v - y0;
            if (mleft) col = 31 - col;
            pix = rom_pix(row, col);
            if (pix != 12'hF0F) c = (mflash % 2 == 1) ? 12'hFFF : pix;
        end
        return {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, c};
    endfunction

    task automatic model_update();
        if (rst) begin
            mbx = 12'd768; mby = 12'd700; mleft = 1'b0; mflash = 0;
        end else begin
            if (frame_tick) begin
                if (boss_x < mbx) mleft = 1'b1;
                else if (boss_x > mbx) mleft = 1'b0;
                mbx = boss_x;
                mby = boss_y;
            end
            if (game_active != 2'd1) mflash = 0;
            else if (boss_hit) mflash = 8;
            else if (frame_tick && mflash > 0) mflash = mflash - 1;
        end
    endtask

    // One clock: push expectation for current inputs, clock, pop the one due now.
    task automatic step();
        logic [37:0] exp_v, act_v;
        if (rst) exp_v = '0;
        else exp_v = model_out();
        if (rst && sbq.size() > 0) sbq[sbq.size() - 1] = '0;
        sbq.push_back(exp_v);
        @(posedge clk);
        #1;
        model_update();
        frame_tick = 1'b0;
        boss_hit   = 1'b0;
        if (sbq.size() >= 2) begin
            exp_v = sbq.pop_front();
            act_v = {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out};
            n_cmp++;
            if (act_v !== exp_v) begin
                n_bad++;
                $display("FAIL scoreboard[%s] t=%0t got %h want %h", cur, $time, act_v, exp_v);
            end
        end
    endtask

    task automatic set_pix(input int h, input int v, input logic [11:0] c);
        hcount_in = 11'(h);
        vcount_in = 11'(v);
        rgb_in    = c;
        hsync_in  = 1'($urandom_range(0, 1));
        vsync_in  = 1'($urandom_range(0, 1));
        hblnk_in  = 1'b0;
        vblnk_in  = 1'b0;
    endtask

    // Drive one pixel then a filler; afterwards the outputs show that pixel.
    task automatic probe(input int h, input int v, input logic [11:0] c);
        set_pix(h, v, c);
        step();
        set_pix(0, 0, 12'h000);
        step();
    endtask

    task automatic test_reset();
        cur = "reset";
        rst = 1'b1;
        set_pix(100, 100, 12'hABC);
        repeat (3) step();
        n_cmp++;
        if ({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out} !== 38'd0) begin
            n_bad++;
            $display("FAIL reset_outputs got %h/%h/%h want all zero", hcount_out, vcount_out, rgb_out);
        end
        rst = 1'b0;
        step();
        step();
    endtask

    task automatic test_centre();
        logic hs, vs;
        cur = "centre";
        game_active = 2'd1;
        boss_x = 12'd500;
        boss_y = 12'd400;
        frame_tick = 1'b1;
        set_pix(0, 0, 12'h000);
        step();
        set_pix(500, 400, 12'hABC);
        hs = hsync_in;
        vs = vsync_in;
        step();
        set_pix(10, 10, 12'h555);
        step();
        n_cmp++;
        if ({hcount_out, vcount_out, hsync_out, vsync_out, rgb_out} !== {11'd500, 11'd400, hs, vs, 12'h123}) begin
            n_bad++;
            $display("FAIL centre_pixel got h=%0d v=%0d rgb=%h want h=500 v=400 rgb=123", hcount_out, vcount_out, rgb_out);
        end
    endtask

    task automatic test_edge();
        cur = "edge";
        probe(483, 400, 12'h0A5);
        n_cmp++;
        if (rgb_out !== 12'h0A5) begin n_bad++; $display("FAIL edge_outside got %h want %h", rgb_out, 12'h0A5); end
        probe(484, 400, 12'h0B6);
        n_cmp++;
        if (rgb_out !== 12'h21F) begin n_bad++; $display("FAIL edge_first_col got %h want %h", rgb_out, 12'h21F); end
        probe(510, 400, 12'h0C7);
        n_cmp++;
        if (rgb_out !== 12'h0C7) begin n_bad++; $display("FAIL key_passthru got %h want %h", rgb_out, 12'h0C7); end
    endtask

    task automatic test_move();
        cur = "move";
        boss_x = 12'd495;
        probe(484, 400, 12'h0D0);
        n_cmp++;
        if (rgb_out !== 12'h21F) begin n_bad++; $display("FAIL no_tick_hold got %h want %h", rgb_out, 12'h21F); end
        probe(479, 400, 12'h0D1);
        n_cmp++;
        if (rgb_out !== 12'h0D1) begin n_bad++; $display("FAIL no_tick_outside got %h want %h", rgb_out, 12'h0D1); end
        frame_tick = 1'b1;
        set_pix(0, 0, 12'h000);
        step();
        probe(479, 400, 12'h0D3);
        n_cmp++;
        if (rgb_out !== 12'h21F) begin n_bad++; $display("FAIL moved_mirror got %h want %h", rgb_out, 12'h21F); end
        boss_x = 12'd505;
        frame_tick = 1'b1;
        step();
        probe(489, 400, 12'h0E1);
        n_cmp++;
        if (rgb_out !== 12'h200) begin n_bad++; $display("FAIL face_right got %h want %h", rgb_out, 12'h200); end
    endtask

    task automatic test_flash();
        int flashes;
        cur = "flash";
        flashes = 0;
        boss_hit = 1'b1;
        step();
        repeat (3) begin
            frame_tick = 1'b1;
            step();
            probe(505, 400, 12'h0F0);
            if (rgb_out === 12'hFFF) flashes++;
        end
        boss_hit = 1'b1;
        step();
        repeat (10) begin
            frame_tick = 1'b1;
            step();
            probe(505, 400, 12'h0F0);
            if (rgb_out === 12'hFFF) flashes++;
        end
        n_cmp++;
        if (flashes != 6) begin n_bad++; $display("FAIL flash_frames got %0d want %0d", flashes, 6); end
        boss_hit = 1'b1;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b1;
        step();
        probe(505, 400, 12'h0F1);
        n_cmp++;
        if (rgb_out !== 12'hFFF) begin n_bad++; $display("FAIL hit_beats_tick got %h want %h", rgb_out, 12'hFFF); end
    endtask

    task automatic test_offscreen();
        cur = "offscreen";
        boss_x = 12'd10;
        frame_tick = 1'b1;
        step();
        probe(0, 400, 12'h011);
        n_cmp++;
        if (rgb_out !== 12'h219) begin n_bad++; $display("FAIL clip_left got %h want %h", rgb_out, 12'h219); end
        probe(1023, 400, 12'h022);
        n_cmp++;
        if (rgb_out !== 12'h022) begin n_bad++; $display("FAIL no_wrap got %h want %h", rgb_out, 12'h022); end
    endtask

    task automatic test_inactive();
        cur = "inactive";
        boss_hit = 1'b1;
        step();
        frame_tick = 1'b1;
        step();
        game_active = 2'd2;
        boss_x = 12'd300;
        frame_tick = 1'b1;
        step();
        probe(300, 400, 12'h033);
        n_cmp++;
        if (rgb_out !== 12'h033) begin n_bad++; $display("FAIL inactive_hidden got %h want %h", rgb_out, 12'h033); end
        game_active = 2'd1;
        probe(300, 400, 12'h044);
        n_cmp++;
        if (rgb_out !== 12'h123) begin n_bad++; $display("FAIL flash_cleared got %h want %h", rgb_out, 12'h123); end
    endtask

    task automatic test_reset_mid();
        cur = "reset_mid";
        set_pix(300, 400, 12'h066);
        rst = 1'b1;
        step();
        n_cmp++;
        if ({hcount_out, rgb_out} !== 23'd0) begin n_bad++; $display("FAIL mid_reset got %h/%h want 0/0", hcount_out, rgb_out); end
        step();
        rst = 1'b0;
        probe(768, 700, 12'h055);
        n_cmp++;
        if ({hcount_out, vcount_out, rgb_out} !== {11'd768, 11'd700, 12'h123}) begin
            n_bad++;
            $display("FAIL reset_position got h=%0d v=%0d rgb=%h want h=768 v=700 rgb=123", hcount_out, vcount_out, rgb_out);
        end
    endtask

    task automatic test_random();
        int h, v;
        cur = "random";
        for (int i = 0; i < 1500; i++) begin
            frame_tick  = ($urandom_range(0, 99) < 5);
            boss_hit    = ($urandom_range(0, 99) < 2);
            rst         = ($urandom_range(0, 199) == 0);
            game_active = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : 2'd1;
            boss_x = 12'(200 + $urandom_range(0, 600));
            boss_y = 12'(100 + $urandom_range(0, 500));
            if (!frame_tick) boss_x = mbx;
            h = int'(mbx) - 24 + int'($urandom_range(0, 48));
            v = int'(mby) - 24 + int'($urandom_range(0, 48));
            if (h < 0) h = 0;
            if (v < 0) v = 0;
            set_pix(h, v, 12'($urandom()));
            hblnk_in = ($urandom_range(0, 9) == 0);
            vblnk_in = ($urandom_range(0, 9) == 0);
            step();
        end
        rst = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        frame_tick = 1'b0;
        boss_hit = 1'b0;
        game_active = 2'd1;
        boss_x = 12'd0;
        boss_y = 12'd0;
        mbx = 12'd768;
        mby = 12'd700;
        mleft = 1'b0;
        mflash = 0;
        set_pix(0, 0, 12'h000);
        test_reset();
        test_centre();
        test_edge();
        test_move();
        test_flash();
        test_offscreen();
        test_inactive();
        test_reset_mid();
        test_random();
        cur = "drain";
        set_pix(0, 0, 12'h000);
        step();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
